regfile_rename_mp: RTL

- Multi-ported architectural register file with per-register rename tags for the Tomasulo/ROB core.
- Holds committed values and, per register, the ROB tag of the newest in-flight producer.
- Serves ISSUE_W decode slots (two source reads each) and accepts ISSUE_W renames plus COMMIT_W commits per cycle.
- Adds same-cycle commit-to-read bypass, prioritised multi-port writes, x0 protection, and a flush that keeps architectural values.

---
 rtl/regfile_rename_mp_pkg.sv | 19 +
 rtl/regfile_rename_mp_rf_read_port.sv | 37 +++
 rtl/regfile_rename_mp.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_rename_mp_pkg.sv
// Shared widths, tag encoding and types for the renamed architectural register file.
package regfile_rename_mp_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned ISSUE_W  = 2;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned NRD      = 2 * ISSUE_W;

    typedef logic [XLEN-1:0]  xlen_t;
    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Tag value meaning "no in-flight producer; stored value is current".
    localparam tag_t TAG_NONE = TAG_W'(0);

endpackage

// File: rtl/regfile_rename_mp_rf_read_port.sv
// One source read path: stored lookup, same-cycle commit bypass, x0 forced to zero.
module regfile_rename_mp_rf_read_port
    import regfile_rename_mp_pkg::*;
(
    input  logic [REG_W-1:0]          rs,
    input  logic [XLEN-1:0]           values [NREG],
    input  logic [TAG_W-1:0]          tags   [NREG],
    input  logic [COMMIT_W*REG_W-1:0] cmt_rd,
    input  logic [COMMIT_W*XLEN-1:0]  cmt_val,
    input  logic [COMMIT_W*TAG_W-1:0] cmt_tag,
    output logic [XLEN-1:0]           val,
    output logic [TAG_W-1:0]          tag
);

    tag_t base_tag;

    assign base_tag = tags[rs];

    // Bypass only when the committing entry is the producer the register waits on.
    always_comb begin
        val = values[rs];
        tag = base_tag;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cmt_rd[c*REG_W +: REG_W] == rs &&
                cmt_rd[c*REG_W +: REG_W] != '0 &&
                cmt_tag[c*TAG_W +: TAG_W] == base_tag) begin
                val = cmt_val[c*XLEN +: XLEN];
                tag = TAG_NONE;
            end
        end
        if (rs == '0) begin
            val = '0;
            tag = TAG_NONE;
        end
    end

endmodule

// File: rtl/regfile_rename_mp.sv
// Multi-ported architectural register file with per-register ROB rename tags,
// commit bypass on reads, and a flush that clears tags but keeps values.
module regfile_rename_mp
    import regfile_rename_mp_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic [ISSUE_W*REG_W-1:0]  ren_rd,
    input  logic [ISSUE_W*TAG_W-1:0]  ren_tag,
    input  logic [COMMIT_W*REG_W-1:0] cmt_rd,
    input  logic [COMMIT_W*XLEN-1:0]  cmt_val,
    input  logic [COMMIT_W*TAG_W-1:0] cmt_tag,
    input  logic [NRD*REG_W-1:0]      rd_rs,
    output logic [NRD*XLEN-1:0]       rd_val,
    output logic [NRD*TAG_W-1:0]      rd_tag,
    output logic                      rf_idle
);

    xlen_t value_q [NREG];
    tag_t  tag_q   [NREG];
    tag_t  tag_d   [NREG];

    // Tag update: commit clears on match, then flush or renames override.
    always_comb begin
        tag_d = tag_q;
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cmt_rd[c*REG_W +: REG_W] != '0 &&
                tag_q[cmt_rd[c*REG_W +: REG_W]] == cmt_tag[c*TAG_W +: TAG_W]) begin
                tag_d[cmt_rd[c*REG_W +: REG_W]] = TAG_NONE;
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = TAG_NONE;
            end
        end else begin
            for (int s = 0; s < ISSUE_W; s++) begin
                if (ren_rd[s*REG_W +: REG_W] != '0) begin
                    tag_d[ren_rd[s*REG_W +: REG_W]] = ren_tag[s*TAG_W +: TAG_W];
                end
            end
        end
        tag_d[0] = TAG_NONE;
    end

    // Higher commit port index lands last and so wins a shared destination.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= TAG_NONE;
            end
        end else if (rdy_in) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (cmt_rd[c*REG_W +: REG_W] != '0) begin
                    value_q[cmt_rd[c*REG_W +: REG_W]] <= cmt_val[c*XLEN +: XLEN];
                end
            end
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    always_comb begin
        rf_idle = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            if (tag_q[r] != TAG_NONE) begin
                rf_idle = 1'b0;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rename_mp_rf_read_port u_port (
            .rs      (rd_rs[p*REG_W +: REG_W]),
            .values  (value_q),
            .tags    (tag_q),
            .cmt_rd  (cmt_rd),
            .cmt_val (cmt_val),
            .cmt_tag (cmt_tag),
            .val     (rd_val[p*XLEN +: XLEN]),
            .tag     (rd_tag[p*TAG_W +: TAG_W])
        );
    end

endmodule
